// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit with ROB-tagged, backpressured result.
// Define MULDIV_DIV_EARLY_OUT_EN to retire |a| < |b| divides right after setup.
module muldiv_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned TAG_W      = 5,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned CNT_W    = $clog2(XLEN + MUL_STAGES) + 1;
  localparam int unsigned MUL_LAST = (MUL_STAGES >= 2) ? MUL_STAGES - 2 : 0;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, rem_q, rem_d;
  logic              neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic              out_valid_d;
  logic [XLEN-1:0]   out_data_d;
  logic [TAG_W-1:0]  out_tag_d;

  logic              accept;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;

  assign in_ready = rst_n && (state_q == IDLE) && !flush;
  assign accept   = in_valid && in_ready;

  // Multiplier sees live inputs in IDLE so a single-stage build can finish at accept.
  logic [2:0]        mul_op;
  logic [XLEN-1:0]   mul_a, mul_b;
  logic              mul_a_sgn, mul_b_sgn;
  logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, prod;
  logic [XLEN-1:0]   mul_res;

  assign mul_op    = (state_q == IDLE) ? in_op : op_q;
  assign mul_a     = (state_q == IDLE) ? in_a  : a_q;
  assign mul_b     = (state_q == IDLE) ? in_b  : b_q;
  assign mul_a_sgn = (mul_op == 3'd1) || (mul_op == 3'd2);
  assign mul_b_sgn = (mul_op == 3'd1);
  assign mul_a_ext = {{XLEN{mul_a_sgn & mul_a[XLEN-1]}}, mul_a};
  assign mul_b_ext = {{XLEN{mul_b_sgn & mul_b[XLEN-1]}}, mul_b};
  assign prod      = mul_a_ext * mul_b_ext;
  assign mul_res   = (mul_op == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // Sign/magnitude setup happens on the accept edge; ops 4 and 6 are signed.
  assign a_neg = !in_op[0] && in_a[XLEN-1];
  assign b_neg = !in_op[0] && in_b[XLEN-1];
  assign a_mag = a_neg ? -in_a : in_a;
  assign b_mag = b_neg ? -in_b : in_b;

  // One restoring step: a_q shifts out dividend bits and collects quotient bits.
  logic [XLEN:0]   trial;
  logic            step_ok;
  logic [XLEN-1:0] rem_step, quo_step, quo_fin, rem_fin, early_rem;
  logic            early;

  assign trial     = {rem_q, a_q[XLEN-1]} - {1'b0, b_q};
  assign step_ok   = !trial[XLEN];
  assign rem_step  = step_ok ? trial[XLEN-1:0] : {rem_q[XLEN-2:0], a_q[XLEN-1]};
  assign quo_step  = {a_q[XLEN-2:0], step_ok};
  assign quo_fin   = neg_quo_q ? -quo_step : quo_step;
  assign rem_fin   = neg_rem_q ? -rem_step : rem_step;
  assign early_rem = neg_rem_q ? -a_q : a_q;

`ifdef MULDIV_DIV_EARLY_OUT_EN
  assign early = (cnt_q == '0) && (a_q < b_q);
`else
  assign early = 1'b0;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rem_d      = rem_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    out_data_d = out_data;
    out_tag_d  = out_tag;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d      = in_op;
          out_tag_d = in_tag;
          cnt_d     = '0;
          if (!in_op[2]) begin
            a_d = in_a;
            b_d = in_b;
            if (MUL_STAGES == 1) begin
              state_d    = DONE;
              out_data_d = mul_res;
            end else begin
              state_d = MUL;
            end
          end else if (in_b == '0) begin
            state_d    = DONE;
            out_data_d = in_op[1] ? in_a : '1;
          end else if (!in_op[0] && (in_a == INT_MIN) && (in_b == '1)) begin
            state_d    = DONE;
            out_data_d = in_op[1] ? '0 : in_a;
          end else begin
            state_d   = DIV;
            a_d       = a_mag;
            b_d       = b_mag;
            rem_d     = '0;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
          end
        end
      end
      MUL: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MUL_LAST)) begin
          state_d    = DONE;
          out_data_d = mul_res;
        end
      end
      DIV: begin
        if (early) begin
          state_d    = DONE;
          out_data_d = op_q[1] ? early_rem : '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          a_d   = quo_step;
          rem_d = rem_step;
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            state_d    = DONE;
            out_data_d = op_q[1] ? rem_fin : quo_fin;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_tag   <= out_tag_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: op results, latencies, backpressure, flush, reset.
module tb_muldiv_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 5;
`ifdef MULDIV_DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = 33;
`endif

  logic             clk = 1'b0;
  logic             rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_a, in_b, out_data;
  logic [TAG_W-1:0] in_tag, out_tag;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .MUL_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  // Accept one op, wait for the result, check it, then take it with out_ready.
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    bit seen;
    string nm;
    nm = $sformatf("v%0d", idx);
    @(negedge clk);
    check({nm, "_rdy"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_op = v.op; in_a = v.a; in_b = v.b; in_tag = v.tag;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0; seen = 1'b0;
    for (int k = 1; k <= 100 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; lat = k; end
    end
    check({nm, "_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check({nm, "_data"}, 64'(out_data), 64'(v.exp));
      check({nm, "_tag"}, 64'(out_tag), 64'(v.tag));
      check({nm, "_lat"}, 64'(lat), 64'(v.lat));
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check({nm, "_vfall"}, 64'(out_valid), 64'd0);
      check({nm, "_rdyrise"}, 64'(in_ready), 64'd1);
    end
  endtask

  initial begin
    int max_valid;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_tag = '0;

    vecs.push_back('{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 2});
    vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000, 2});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFF, 2});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 2});
    vecs.push_back('{3'd0, 32'h8000_0000, 32'h8000_0000, 5'd7,  32'h0000_0000, 2});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd8,  32'hFFFF_FFFD, 33});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  32'hFFFF_FFFF, 33});
    vecs.push_back('{3'd5, 32'd100,       32'd7,         5'd10, 32'd14,        33});
    vecs.push_back('{3'd7, 32'd100,       32'd7,         5'd11, 32'd2,         33});
    vecs.push_back('{3'd4, 32'd5,         32'd0,         5'd12, 32'hFFFF_FFFF, 1});
    vecs.push_back('{3'd6, 32'd5,         32'd0,         5'd13, 32'd5,         1});
    vecs.push_back('{3'd5, 32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF, 1});
    vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1});
    vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0000_0000, 1});
    vecs.push_back('{3'd5, 32'd3,         32'd10,        5'd17, 32'd0,         EARLY_LAT});
    vecs.push_back('{3'd7, 32'd3,         32'd10,        5'd18, 32'd3,         EARLY_LAT});
    vecs.push_back('{3'd6, 32'hFFFF_FFFD, 32'd10,        5'd19, 32'hFFFF_FFFD, EARLY_LAT});
    vecs.push_back('{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'd0,         EARLY_LAT});
    vecs.push_back('{3'd4, 32'd100,       32'hFFFF_FFF9, 5'd21, 32'hFFFF_FFF2, 33});

    #2;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_tag", 64'(out_tag), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Backpressure: DIVU result must hold for 10 cycles without out_ready.
    begin
      bit seen;
      seen = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; in_op = 3'd5; in_a = 32'd100; in_b = 32'd7; in_tag = 5'd9;
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int k = 1; k <= 100 && !seen; k++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      check("bp_seen", 64'(seen), 64'd1);
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        check("bp_valid", 64'(out_valid), 64'd1);
        check("bp_data", 64'(out_data), 64'd14);
        check("bp_tag", 64'(out_tag), 64'd9);
        check("bp_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check("bp_vfall", 64'(out_valid), 64'd0);
      check("bp_rdyrise", 64'(in_ready), 64'd1);
    end

    // Flush at the tenth edge after a DIV accept.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd4; in_a = 32'hFFFF_FFF9; in_b = 32'd2; in_tag = 5'd22;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    check("fl_busy_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("fl_ready", 64'(in_ready), 64'd1);
    max_valid = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) max_valid = 1;
    end
    check("fl_no_result", 64'(max_valid), 64'd0);

    // A request offered during flush must be dropped.
    in_valid = 1'b1; in_op = 3'd0; in_a = 32'd2; in_b = 32'd3; in_tag = 5'd23;
    flush = 1'b1;
    #1 check("fl_req_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 begin flush = 1'b0; in_valid = 1'b0; end
    max_valid = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (out_valid) max_valid = 1;
    end
    check("fl_req_dropped", 64'(max_valid), 64'd0);
    check("fl_req_idle", 64'(in_ready), 64'd1);

    // Asynchronous reset while a MUL is in flight.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd0; in_a = 32'd6; in_b = 32'd7; in_tag = 5'd24;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("mr_busy", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("mr_valid", 64'(out_valid), 64'd0);
    check("mr_data", 64'(out_data), 64'd0);
    check("mr_tag", 64'(out_tag), 64'd0);
    check("mr_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    max_valid = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_valid) max_valid = 1;
    end
    check("mr_no_result", 64'(max_valid), 64'd0);
    check("mr_idle", 64'(in_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised multi-cycle integer multiply/divide functional unit (RV32M ops) for the out-of-order core. It sits beside the single-cycle ALU behind a reservation station and accepts one micro-op at a time through a valid/ready handshake. Each result is tagged with its ROB index and held until the CDB arbiter accepts it. A flush input kills in-flight work.

Parameters:
XLEN, 32, operand/result width (even, >=8)
TAG_W, 5, ROB tag width
MUL_STAGES, 2, multiply latency in cycles (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  kill in-flight op; unit returns to IDLE
in_valid  in  1  request valid
in_ready  out  1  unit can accept request
in_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
in_a  in  XLEN  rs1 operand
in_b  in  XLEN  rs2 operand
in_tag  in  TAG_W  ROB tag
out_valid  out  1  result valid
out_ready  in  1  CDB grant
out_data  out  XLEN  result
out_tag  out  TAG_W  tag of result

Behaviour:
- Clocking: single clk; rst_n asynchronous assert, synchronous release. State elements clear when rst_n=0.
- Reset values: state=IDLE, out_valid=0, out_data=0, out_tag=0. in_ready=0 while rst_n=0.
- in_ready = (state==IDLE) && !flush. An op is accepted when in_valid && in_ready at a rising edge; call that edge T. Operands, op and tag are captured at T.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE -> MUL: on accept of ops 0-3.
  - IDLE -> DIV: on accept of ops 4-7 (normal case).
  - IDLE -> DONE: on accept of ops 4-7 in a special case.
  - MUL -> DONE: after MUL_STAGES-1 further edges.
  - DIV -> DONE: after the XLEN-th iteration.
  - DONE -> IDLE: on edge with out_ready=1.
- Latency, measured from T to the first cycle with out_valid=1:
  - MUL ops: MUL_STAGES cycles.
  - DIV ops: XLEN+1 cycles (1 sign/abs setup cycle, then XLEN radix-2 restoring iterations, one per cycle).
  - Special cases: 1 cycle.
- Multiply: full 2*XLEN product.
  - MUL returns the low XLEN bits.
  - MULH: signed x signed, high half.
  - MULHSU: signed a x unsigned b, high half.
  - MULHU: unsigned x unsigned, high half.
- Divide: signed ops operate on magnitudes; the quotient sign is sign(a)^sign(b) and the remainder takes the sign of a.
- Divide special cases:
  - b==0: quotient = all ones; remainder = a.
  - Signed overflow (a = -2^(XLEN-1), b = -1, DIV/REM): quotient = a; remainder = 0.
- Output rules:
  - out_valid=1 only in DONE.
  - out_data and out_tag are stable while out_valid && !out_ready.
  - After a transfer, out_valid falls the next cycle and in_ready rises the same cycle as that fall.
  - No overlap: maximum throughput is 1 op per MUL_STAGES+1 cycles.
- Flush: when flush=1 at an edge, the unit goes to IDLE from any state and clears out_valid; an unsent result is discarded. A request presented while flush=1 is not accepted. flush together with out_ready in DONE means the result is not counted as delivered; the ROB discards it either way.
- Mid-operation reset: asynchronous return to reset values; no partial result is ever emitted.
- Undefined-free: in_op covers all 8 codes; there is no default/illegal path.

Optional Feature:
MULDIV_DIV_EARLY_OUT_EN
- Defined: unsigned DIVU/REMU, and signed ops after magnitude conversion, with |a| < |b| and b!=0 complete in the special-case path. Result: quotient 0, remainder a, latency 2 cycles (setup + DONE).
- Undefined: these cases run the full XLEN+1 latency. Results are identical in both configurations; only timing differs.

Test Plan:
1. MUL a=7, b=0xFFFFFFFD (-3) -> out_data=0xFFFFFFEB, out_valid at T+2 (MUL_STAGES=2), out_tag = in_tag.
2. MULH a=b=0x80000000 -> 0x40000000. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF. MULHU same operands -> 0xFFFFFFFE.
3. DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD at T+33. REM with the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
4. DIV a=5, b=0 -> 0xFFFFFFFF at T+1. REM a=5, b=0 -> 5. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0.
5. Backpressure: hold out_ready=0 for 10 cycles after DIVU completes -> out_data/out_tag stable and in_ready=0. Raise out_ready -> one transfer; in_ready=1 the next cycle.
6. Flush mid-DIV (cycle T+10) -> out_valid never rises and in_ready=1 at T+11. Next, assert rst_n=0 mid-MUL -> all outputs immediately at reset values.
